// File: rtl/div_stage_if.sv
// div_stage_if: issue and writeback signal bundle between the execute stage and the iterative divider.
interface div_stage_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 7
);
    logic            div_en;
    logic            kill;
    logic [1:0]      funct3;
    logic [XLEN-1:0] r_RD1;
    logic [XLEN-1:0] r_RD2;
    logic [TAGW-1:0] tailE;
    logic [4:0]      r_WA;
    logic [XLEN-1:0] PC_plus4E;
    logic            busy;
    logic [4:0]      r_WA_pend;
    logic            div_done;
    logic [XLEN-1:0] result;
    logic [4:0]      r_WA_DV;
    logic [TAGW-1:0] tail_DV;
    logic [XLEN-1:0] PC_plus4DV;

    modport master (
        output div_en, kill, funct3, r_RD1, r_RD2, tailE, r_WA, PC_plus4E,
        input  busy, r_WA_pend, div_done, result, r_WA_DV, tail_DV, PC_plus4DV
    );

    modport slave (
        input  div_en, kill, funct3, r_RD1, r_RD2, tailE, r_WA, PC_plus4E,
        output busy, r_WA_pend, div_done, result, r_WA_DV, tail_DV, PC_plus4DV
    );
endinterface

// File: rtl/div_stage.sv
// div_stage: iterative RV32M DIV/DIVU/REM/REMU, one restoring step per cycle on operand magnitudes.
module div_stage #(
    parameter int XLEN      = 32,
    parameter int TAGW      = 7,
    parameter bit EARLY_OUT = 1
) (
    input logic        clk,
    input logic        rstn,
    div_stage_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] q, rem, dvs, spec_val;
    logic            rem_op, neg_q, neg_r, spec;
    logic            sgn, a_neg, b_neg, spec_in;
    logic [XLEN-1:0] spec_in_val, q_nx, rem_nx, q_fin, rem_fin;
    logic [XLEN:0]   sh, diff;

    always_comb begin
        sgn         = !bus.funct3[0];
        a_neg       = sgn && bus.r_RD1[XLEN-1];
        b_neg       = sgn && bus.r_RD2[XLEN-1];
        spec_in     = bus.r_RD2 == '0 || (sgn && bus.r_RD1 == MIN && bus.r_RD2 == '1);
        spec_in_val = bus.r_RD2 == '0 ? (bus.funct3[1] ? bus.r_RD1 : '1) : (bus.funct3[1] ? '0 : MIN);
        // q shifts its MSB into the partial remainder as the quotient bits fill from the bottom
        sh          = {rem, q[XLEN-1]};
        diff        = sh - {1'b0, dvs};
        rem_nx      = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
        q_nx        = {q[XLEN-2:0], !diff[XLEN]};
        q_fin       = neg_q ? -q_nx : q_nx;
        rem_fin     = neg_r ? -rem_nx : rem_nx;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            count          <= '0;
            q              <= '0;
            rem            <= '0;
            dvs            <= '0;
            spec_val       <= '0;
            rem_op         <= 1'b0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            spec           <= 1'b0;
            bus.result     <= '0;
            bus.r_WA_DV    <= '0;
            bus.tail_DV    <= '0;
            bus.PC_plus4DV <= '0;
        end else if (bus.kill) begin
            state <= IDLE;
            count <= '0;
        end else if (state == IDLE) begin
            if (bus.div_en) begin
                state          <= (EARLY_OUT && spec_in) ? DONE : CALC;
                count          <= '0;
                q              <= a_neg ? -bus.r_RD1 : bus.r_RD1;
                rem            <= '0;
                dvs            <= b_neg ? -bus.r_RD2 : bus.r_RD2;
                spec           <= spec_in;
                spec_val       <= spec_in_val;
                rem_op         <= bus.funct3[1];
                neg_q          <= a_neg ^ b_neg;
                neg_r          <= a_neg;
                bus.r_WA_DV    <= bus.r_WA;
                bus.tail_DV    <= bus.tailE;
                bus.PC_plus4DV <= bus.PC_plus4E;
                if (EARLY_OUT && spec_in) bus.result <= spec_in_val;
            end
        end else if (state == CALC) begin
            q     <= q_nx;
            rem   <= rem_nx;
            count <= count + 1'b1;
            if (count == CW'(XLEN-1)) begin
                state      <= DONE;
                bus.result <= spec ? spec_val : rem_op ? rem_fin : q_fin;
            end
        end else begin
            state <= IDLE;
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.r_WA_pend = state != IDLE ? bus.r_WA_DV : '0;
    // a flush landing in the DONE cycle must swallow the completion pulse immediately
    assign bus.div_done  = state == DONE && !bus.kill;
endmodule

// File: tb/tb_div_stage.sv
// tb_div_stage: directed and random RV32M divide checks against a plain-arithmetic reference model.
module tb_div_stage;
    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    div_stage_if bus ();
    div_stage dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
        case (f)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic bit special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        return b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic [6:0] tg, input logic [31:0] pc);
        bus.div_en    = 1'b1;
        bus.funct3    = f;
        bus.r_RD1     = a;
        bus.r_RD2     = b;
        bus.r_WA      = wa;
        bus.tailE     = tg;
        bus.PC_plus4E = pc;
        tick();
        bus.div_en    = 1'b0;
        bus.r_RD1     = $urandom;
        bus.r_RD2     = $urandom;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " done"}, bus.div_done, 0);
        check({tag, " result"}, bus.result, 0);
        check({tag, " pend"}, bus.r_WA_pend, 0);
        check({tag, " wa"}, bus.r_WA_DV, 0);
        check({tag, " tail"}, bus.tail_DV, 0);
        check({tag, " pc"}, bus.PC_plus4DV, 0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic [4:0]  wa;
        logic [6:0]  tg;
        logic [31:0] pc, exp;
        wa  = 5'($urandom);
        tg  = 7'($urandom);
        pc  = $urandom;
        exp = model(f, a, b);
        issue(f, a, b, wa, tg, pc);
        check({tag, " busy"}, bus.busy, 1);
        lat = 1;
        while (!bus.div_done && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, special(f, a, b) ? 1 : 33);
        check({tag, " result"}, bus.result, exp);
        check({tag, " wa"}, bus.r_WA_DV, wa);
        check({tag, " tail"}, bus.tail_DV, tg);
        check({tag, " pc"}, bus.PC_plus4DV, pc);
        check({tag, " pend"}, bus.r_WA_pend, wa);
        tick();
        check({tag, " done pulse"}, bus.div_done, 0);
        check({tag, " idle"}, bus.busy, 0);
        check({tag, " held"}, bus.result, exp);
    endtask

    initial begin
        bit seen;
        int lat;
        bus.div_en    = 1'b0;
        bus.kill      = 1'b0;
        bus.funct3    = 2'b00;
        bus.r_RD1     = '0;
        bus.r_RD2     = '0;
        bus.r_WA      = '0;
        bus.tailE     = '0;
        bus.PC_plus4E = '0;
        rstn          = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        rstn = 1'b1;
        tick();

        run_op("divu 100/7", 2'b01, 100, 7);
        run_op("remu 100/7", 2'b11, 100, 7);
        run_op("div -7/2", 2'b00, -32'sd7, 2);
        run_op("rem -7/2", 2'b10, -32'sd7, 2);
        run_op("rem 7/-2", 2'b10, 7, -32'sd2);
        run_op("divu 5/0", 2'b01, 5, 0);
        run_op("rem min/0", 2'b10, 32'h8000_0000, 0);
        run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 1);

        // kill at T+10, then a fresh op issued on the edge ending T+11
        issue(2'b01, 1000, 3, 5'd4, 7'd11, 32'h100);
        seen = 0;
        for (int i = 1; i < 10; i++) begin
            seen |= bus.div_done;
            tick();
        end
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        check("kill busy", bus.busy, 0);
        run_op("divu 9/3 after kill", 2'b01, 9, 3);
        for (int i = 0; i < 40; i++) begin
            seen |= bus.div_done;
            tick();
        end
        check("kill no done", seen, 0);

        // kill during the DONE cycle
        issue(2'b01, 50, 5, 5'd7, 7'd3, 32'h200);
        for (int i = 1; i < 33; i++) tick();
        check("pre-kill done", bus.div_done, 1);
        bus.kill = 1'b1;
        #1;
        check("kill in done", bus.div_done, 0);
        tick();
        bus.kill = 1'b0;
        check("kill done busy", bus.busy, 0);
        check("kill done pulse", bus.div_done, 0);

        // second issue while busy is ignored
        issue(2'b01, 100, 7, 5'd3, 7'd21, 32'h300);
        for (int i = 1; i < 5; i++) tick();
        bus.div_en = 1'b1;
        bus.funct3 = 2'b11;
        bus.r_RD1  = 1;
        bus.r_RD2  = 1;
        bus.r_WA   = 5'd9;
        bus.tailE  = 7'd99;
        tick();
        bus.div_en = 1'b0;
        lat = 6;
        while (!bus.div_done && lat < 100) begin
            tick();
            lat++;
        end
        check("ignored latency", lat, 33);
        check("ignored result", bus.result, 14);
        check("ignored wa", bus.r_WA_DV, 3);
        check("ignored tail", bus.tail_DV, 21);
        tick();

        // reset mid-operation at T+20
        issue(2'b00, 12345, 17, 5'd12, 7'd40, 32'h400);
        for (int i = 1; i < 20; i++) tick();
        rstn = 1'b0;
        tick();
        check_idle_zero("mid reset");
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            seen |= bus.div_done;
            tick();
        end
        check("mid reset no done", seen, 0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  f;
            logic [31:0] a, b;
            f = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (i % 8 == 7) a = 32'h8000_0000;
            run_op($sformatf("rand%0d f%0d", i, f), f, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
